// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one 8-bit left barrel shifter between two requesters.
// Amounts 8..15 are applied as three passes: amt[2:0], then 4, then 4.
module barrel_shifter (
  input  logic [7:0] i_data,
  input  logic [2:0] i_shamt,
  output logic [7:0] o_data
);
  logic [7:0] w_s1;
  logic [7:0] w_s2;

  assign w_s1   = i_shamt[0] ? {i_data[6:0], 1'b0} : i_data;
  assign w_s2   = i_shamt[1] ? {w_s1[5:0], 2'b00}  : w_s1;
  assign o_data = i_shamt[2] ? {w_s2[3:0], 4'h0}   : w_s2;
endmodule

module shift_arbiter #(
  parameter int   DATA_W    = 8,
  parameter int   AMT_W     = 4,
  parameter logic PRIO_INIT = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [AMT_W-1:0]  req0_amt,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_data,
  input  logic [AMT_W-1:0]  req1_amt,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_id,
  output logic              busy
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_OUT
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_acc;
  logic [AMT_W-1:0]  r_amt;
  logic              r_id;
  logic              r_last;
  logic [1:0]        r_pass;

  logic              w_idle;
  logic              w_grant;
  logic              w_acc0;
  logic              w_acc1;
  logic              w_last_pass;
  logic [2:0]        w_mag;
  logic [DATA_W-1:0] w_shifted;

  assign w_idle  = (r_state == S_IDLE);
  // On a tie the requester not served last wins
  assign w_grant = (req0_valid && req1_valid) ? ~r_last : req1_valid;
  assign w_acc0  = w_idle && !w_grant && req0_valid;
  assign w_acc1  = w_idle &&  w_grant && req1_valid;

  assign w_mag       = (r_pass == 2'd0) ? r_amt[2:0] : 3'd4;
  assign w_last_pass = r_amt[3] ? (r_pass == 2'd2) : 1'b1;

  barrel_shifter u_bsh (
    .i_data  (r_acc),
    .i_shamt (w_mag),
    .o_data  (w_shifted)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_acc0 || w_acc1) w_next = S_SHIFT;
      S_SHIFT: if (w_last_pass)      w_next = S_OUT;
      S_OUT:   if (res_ready)        w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req0_ready = w_acc0;
    req1_ready = w_acc1;
    res_valid  = (r_state == S_OUT);
    res_data   = r_acc;
    res_id     = r_id;
    busy       = !w_idle;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_amt  <= '0;
      r_id   <= 1'b0;
      r_pass <= 2'd0;
      r_last <= ~PRIO_INIT;
    end else begin
      unique case (1'b1)
        w_acc0: begin
          r_acc  <= req0_data;
          r_amt  <= req0_amt;
          r_id   <= 1'b0;
          r_pass <= 2'd0;
        end
        w_acc1: begin
          r_acc  <= req1_data;
          r_amt  <= req1_amt;
          r_id   <= 1'b1;
          r_pass <= 2'd0;
        end
        (r_state == S_SHIFT): begin
          r_acc  <= w_shifted;
          r_pass <= r_pass + 2'd1;
        end
        (r_state == S_OUT && res_ready): r_last <= r_id;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_arbiter.sv
// Scoreboard bench for shift_arbiter: driver pushes expected results,
// a negedge monitor pops and compares on each result handshake.
module tb_shift_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready;
  logic [7:0] req0_data;
  logic [3:0] req0_amt;
  logic       req1_valid, req1_ready;
  logic [7:0] req1_data;
  logic [3:0] req1_amt;
  logic       res_valid, res_ready;
  logic [7:0] res_data;
  logic       res_id, busy;

  int checks = 0;
  int errors = 0;
  int n_pop  = 0;
  logic [8:0] sb[$];

  always #5 clk = ~clk;

  shift_arbiter #(.DATA_W(8), .AMT_W(4), .PRIO_INIT(1'b0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_amt   (req0_amt),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_amt   (req1_amt),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_id     (res_id),
    .busy       (busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (req0_ready && req1_ready) begin
        errors++;
        $display("FAIL ready_excl: got both ready expected at most one");
      end
      if (res_valid && res_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got id=%0d data=%02h expected none",
                   res_id, res_data);
        end else begin
          logic [8:0] e;
          e = sb.pop_front();
          if ({res_id, res_data} != e) begin
            errors++;
            $display("FAIL result: got id=%0d data=%02h expected id=%0d data=%02h",
                     res_id, res_data, e[8], e[7:0]);
          end
        end
        n_pop++;
      end
    end
  end

  task automatic drive(input int n, input logic v,
                       input logic [7:0] d, input logic [3:0] a);
    if (n == 0) begin
      req0_valid = v; req0_data = d; req0_amt = a;
    end else begin
      req1_valid = v; req1_data = d; req1_amt = a;
    end
  endtask

  task automatic wait_accept(input int n);
    bit ok;
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if ((n == 0) ? req0_ready : req1_ready) begin
        ok = 1;
        break;
      end
    end
    chk($sformatf("accept_req%0d", n), int'(ok), 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send(input int n, input logic [7:0] d, input logic [3:0] a,
                      input logic [7:0] exp, input int lat_exp);
    int lat;
    sb.push_back({n[0], exp});
    @(posedge clk); #1;
    drive(n, 1'b1, d, a);
    wait_accept(n);
    @(posedge clk); #1;
    drive(n, 1'b0, ~d, ~a);
    lat = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (res_valid) break;
      lat++;
    end
    chk($sformatf("latency_%02h_amt%0d", d, a), lat, lat_exp);
    @(posedge clk);
  endtask

  initial begin
    int base;
    bit ok;
    rst_n = 1'b0;
    res_ready = 1'b0;
    drive(0, 1'b0, 8'h00, 4'h0);
    drive(1, 1'b0, 8'h00, 4'h0);
    repeat (2) @(negedge clk);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_res_data", int'(res_data), 0);
    chk("rst_res_id", int'(res_id), 0);
    chk("rst_ready", int'({req0_ready, req1_ready}), 0);
    #1 rst_n = 1'b1;
    res_ready = 1'b1;

    send(0, 8'h01, 4'd3, 8'h08, 1);
    send(1, 8'hFF, 4'd9, 8'h00, 3);
    send(1, 8'h03, 4'd10, 8'h00, 3);
    send(0, 8'hA5, 4'd0, 8'hA5, 1);
    send(0, 8'h81, 4'd7, 8'h80, 1);

    // both requesters valid continuously from a fresh reset
    do_reset();
    base = n_pop;
    sb.push_back({1'b0, 8'h22});
    sb.push_back({1'b1, 8'h88});
    sb.push_back({1'b0, 8'h22});
    sb.push_back({1'b1, 8'h88});
    @(posedge clk); #1;
    drive(0, 1'b1, 8'h11, 4'd1);
    drive(1, 1'b1, 8'h22, 4'd2);
    ok = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      if (n_pop >= base + 4) begin
        ok = 1;
        break;
      end
    end
    #1;
    drive(0, 1'b0, 8'h00, 4'h0);
    drive(1, 1'b0, 8'h00, 4'h0);
    chk("rr_four_results", int'(ok), 1);

    // consumer stalls in OUT
    @(posedge clk); #1;
    res_ready = 1'b0;
    base = n_pop;
    sb.push_back({1'b0, 8'h80});
    drive(0, 1'b1, 8'h40, 4'd1);
    wait_accept(0);
    @(posedge clk); #1;
    drive(0, 1'b0, 8'h00, 4'h0);
    drive(1, 1'b1, 8'h77, 4'd4);
    ok = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (res_valid) begin
        ok = 1;
        break;
      end
    end
    chk("stall_res_valid", int'(ok), 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_data", k), int'(res_data), 8'h80);
      chk($sformatf("stall%0d_id", k), int'(res_id), 0);
      chk($sformatf("stall%0d_ready", k), int'({req0_ready, req1_ready}), 0);
      chk($sformatf("stall%0d_busy", k), int'(busy), 1);
    end
    @(posedge clk); #1;
    sb.push_back({1'b1, 8'h50});
    drive(1, 1'b1, 8'h05, 4'd4);
    res_ready = 1'b1;
    wait_accept(1);
    @(posedge clk); #1;
    drive(1, 1'b0, 8'h00, 4'h0);
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      if (n_pop >= base + 2) begin
        ok = 1;
        break;
      end
    end
    chk("stall_two_results", int'(ok), 1);

    // reset during SHIFT discards the operation
    @(posedge clk); #1;
    base = n_pop;
    drive(1, 1'b1, 8'hFF, 4'd9);
    wait_accept(1);
    @(posedge clk); #1;
    drive(1, 1'b0, 8'h00, 4'h0);
    @(negedge clk);
    chk("pre_rst_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_res_valid", int'(res_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_res_data", int'(res_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("post_rst_no_result", n_pop - base, 0);
    chk("post_rst_busy", int'(busy), 0);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
